// File: rtl/byte_lane_arbiter.sv
// byte_lane_arbiter: round-robin arbiter sharing one DATA_W byte lane between
// NUM_REQ requesters. A grant lasts for one burst (until req_last or MAX_BURST
// beats), and each forwarded beat lands in a single-entry output register
// tagged with its source index.
// Optional: define BYTE_LANE_ARBITER_STATS_EN to add beat_count/grant_count.
module byte_lane_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_src,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       busy
`ifdef BYTE_LANE_ARBITER_STATS_EN
  ,
  output logic [31:0]                beat_count,
  output logic [15:0]                grant_count
`endif
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CNT_W = 8;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                          state;
  logic [SRC_W-1:0]                gnt;
  logic [SRC_W-1:0]                rr_ptr;
  logic [CNT_W-1:0]                beat_cnt;
  logic [SRC_W-1:0]                arb_idx;
  logic                            arb_found;
  logic                            req_hs;
  logic                            out_hs;
  logic [NUM_REQ-1:0][DATA_W-1:0]  data_a;

  assign data_a = req_data;

  // Round-robin pick: first valid index after rr_ptr, wrapping explicitly mod NUM_REQ
  always_comb begin
    int c;
    c         = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (int'(rr_ptr) + k) % NUM_REQ;
      if (!arb_found && req_valid[SRC_W'(c)]) begin
        arb_found = 1'b1;
        arb_idx   = SRC_W'(c);
      end
    end
  end

  // Only the granted requester sees ready, and only when the output slot frees up
  always_comb begin
    req_ready = '0;
    if (!rst && state == GRANT)
      req_ready[gnt] = !out_valid || out_ready;
  end

  assign req_hs = (state == GRANT) && req_valid[gnt] && req_ready[gnt];
  assign out_hs = out_valid && out_ready;

  // Grant FSM: IDLE arbitrates (no data moves), GRANT holds the lane until last/limit
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      rr_ptr   <= SRC_W'(NUM_REQ - 1);
      beat_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            gnt      <= arb_idx;
            rr_ptr   <= arb_idx;
            beat_cnt <= '0;
            state    <= GRANT;
            busy     <= 1'b1;
          end
        end
        GRANT: begin
          if (req_hs) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (req_last[gnt] || (beat_cnt + 1'b1) == CNT_W'(MAX_BURST)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Single-entry output stage; a reload on the same cycle as an drain keeps it full
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_last  <= 1'b0;
    end else if (req_hs) begin
      out_valid <= 1'b1;
      out_data  <= data_a[gnt];
      out_src   <= gnt;
      out_last  <= req_last[gnt];
    end else if (out_hs) begin
      out_valid <= 1'b0;
    end
  end

`ifdef BYTE_LANE_ARBITER_STATS_EN
  // Free-running wrap-around counters of delivered beats and issued grants
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_count  <= '0;
      grant_count <= '0;
    end else begin
      if (out_hs)
        beat_count <= beat_count + 32'd1;
      if (state == IDLE && arb_found)
        grant_count <= grant_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_byte_lane_arbiter.sv
// Self-checking bench for byte_lane_arbiter: per-requester beat queues drive
// the inputs, expected output beats go into a scoreboard queue, and a monitor
// pops and compares on every output handshake.
module tb_byte_lane_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data  = '0;
  logic [N-1:0]   req_last  = '0;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic           out_last;
  logic           out_ready = 1'b1;
  logic           busy;
`ifdef BYTE_LANE_ARBITER_STATS_EN
  logic [31:0]    beat_count;
  logic [15:0]    grant_count;
`endif

  byte_lane_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_last(out_last), .out_ready(out_ready), .busy(busy)
`ifdef BYTE_LANE_ARBITER_STATS_EN
    , .beat_count(beat_count), .grant_count(grant_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // per-requester beat storage {last, data}
  logic [8:0]  bq [N][16];
  int          brd [N];
  int          bwr [N];
  // scoreboard entries {src, last, data}
  logic [10:0] exp_q [$];

  task automatic clear_beats();
    for (int i = 0; i < N; i++) begin
      brd[i] = 0;
      bwr[i] = 0;
    end
  endtask

  task automatic push_beat(input int i, input logic [7:0] d, input logic l, input bit expect_out);
    bq[i][bwr[i]] = {l, d};
    bwr[i]++;
    if (expect_out) exp_q.push_back({2'(i), l, d});
  endtask

  function automatic bit pending();
    pending = 1'b0;
    for (int i = 0; i < N; i++) if (brd[i] < bwr[i]) pending = 1'b1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (brd[i] < bwr[i]) begin
        req_valid[i]       = 1'b1;
        req_last[i]        = bq[i][brd[i]][8];
        req_data[i*W +: W] = bq[i][brd[i]][7:0];
      end else begin
        req_valid[i]       = 1'b0;
        req_last[i]        = 1'b0;
        req_data[i*W +: W] = '0;
      end
    end
  endtask

  // one clock: capture handshakes away from the edge, then advance the requester queues
  task automatic step();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) brd[i]++;
    drive();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || pending() || out_valid !== 1'b0) && n < 60) begin
      step();
      n++;
    end
    tests++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_drain: %0d beats outstanding, out_valid=%b (required 0 and 0)",
               name, exp_q.size(), out_valid);
    end
  endtask

  // scoreboard monitor: every output handshake must match the next expected beat
  always @(negedge clk) begin : monitor
    logic [10:0] e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard: unexpected beat src=%0d data=%h last=%b", out_src, out_data, out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_src, out_last, out_data} !== e) begin
          fails++;
          $display("FAIL scoreboard: got src=%0d last=%b data=%h, required src=%0d last=%b data=%h",
                   out_src, out_last, out_data, e[10:9], e[8], e[7:0]);
        end
      end
    end
  end

  task automatic test_reset();
    int n;
    rst = 1'b1;
    out_ready = 1'b1;
    clear_beats();
    for (int i = 0; i < N; i++) push_beat(i, 8'(8'h40 + i), 1'b1, 1'b1);
    drive();
    repeat (3) begin
      step();
      tests += 3;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
      if (req_ready !== 4'b0) begin fails++; $display("FAIL reset_req_ready: got %b required 0000", req_ready); end
      if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", busy); end
`ifdef BYTE_LANE_ARBITER_STATS_EN
      tests++;
      if (beat_count !== 32'd0 || grant_count !== 16'd0) begin
        fails++;
        $display("FAIL reset_stats: got %0d/%0d required 0/0", beat_count, grant_count);
      end
`endif
    end
    rst = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 10) begin step(); n++; end
    tests++;
    if (out_valid !== 1'b1 || out_src !== 2'd0) begin
      fails++;
      $display("FAIL reset_first_grant: got valid=%b src=%0d required valid=1 src=0", out_valid, out_src);
    end
    wait_drain("reset");
  endtask

  task automatic test_single_burst();
    int n = 0;
    logic [7:0] d [3];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    clear_beats();
    for (int j = 0; j < 3; j++) push_beat(2, d[j], (j == 2), 1'b1);
    drive();
    while (out_valid !== 1'b1 && n < 10) begin step(); n++; end
    for (int j = 0; j < 3; j++) begin
      if (j != 0) step();
      tests++;
      if (out_valid !== 1'b1 || out_data !== d[j] || out_src !== 2'd2 || out_last !== (j == 2)) begin
        fails++;
        $display("FAIL single_beat%0d: got v=%b data=%h src=%0d last=%b required v=1 data=%h src=2 last=%b",
                 j, out_valid, out_data, out_src, out_last, d[j], (j == 2));
      end
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_after_last: got %b required 0", busy); end
    wait_drain("single");
  endtask

  task automatic test_round_robin();
    int n = 0;
    clear_beats();
    push_beat(0, 8'h01, 1'b1, 1'b1);
    push_beat(1, 8'h81, 1'b1, 1'b1);
    push_beat(0, 8'h02, 1'b1, 1'b1);
    push_beat(1, 8'h82, 1'b1, 1'b1);
    drive();
    while (out_valid !== 1'b1 && n < 10) begin step(); n++; end
    for (int j = 0; j < 7; j++) begin
      if (j != 0) step();
      tests++;
      if (j % 2 == 0) begin
        if (out_valid !== 1'b1 || out_src !== 2'((j / 2) % 2)) begin
          fails++;
          $display("FAIL rr_slot%0d: got v=%b src=%0d required v=1 src=%0d", j, out_valid, out_src, (j / 2) % 2);
        end
      end else if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL rr_bubble%0d: got out_valid=%b required 0", j, out_valid);
      end
    end
    wait_drain("round_robin");
  endtask

  task automatic test_burst_limit();
    clear_beats();
    // expected order: 4 beats from src 3, forced release, src 1 burst, then rest of src 3
    for (int j = 0; j < 4; j++) push_beat(3, 8'(8'hA0 + j), 1'b0, 1'b1);
    push_beat(1, 8'h71, 1'b0, 1'b1);
    push_beat(1, 8'h72, 1'b1, 1'b1);
    push_beat(3, 8'hA4, 1'b0, 1'b1);
    push_beat(3, 8'hA5, 1'b1, 1'b1);
    drive();
    wait_drain("burst_limit");
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL burst_limit_busy: got %b required 0", busy); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    clear_beats();
    push_beat(0, 8'h59, 1'b0, 1'b1);
    push_beat(0, 8'h5A, 1'b0, 1'b1);
    push_beat(0, 8'h5B, 1'b0, 1'b1);
    push_beat(0, 8'h5C, 1'b1, 1'b1);
    drive();
    while (!(out_valid === 1'b1 && out_data === 8'h5A) && n < 20) begin step(); n++; end
    out_ready = 1'b0;
    repeat (4) begin
      step();
      tests += 2;
      if (out_valid !== 1'b1 || out_data !== 8'h5A || out_src !== 2'd0 || out_last !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold: got v=%b data=%h src=%0d last=%b required v=1 data=5a src=0 last=0",
                 out_valid, out_data, out_src, out_last);
      end
      if (req_ready !== 4'b0) begin fails++; $display("FAIL bp_req_ready: got %b required 0000", req_ready); end
    end
    out_ready = 1'b1;
    wait_drain("backpressure");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_beats();
    for (int j = 0; j < 4; j++) push_beat(2, 8'(8'hC1 + j), (j == 3), (j < 2));
    drive();
    while (!(out_valid === 1'b1 && out_data === 8'hC2) && n < 20) begin step(); n++; end
    rst = 1'b1;
    step();
    tests += 3;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_out_valid: got %b required 0", out_valid); end
    if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b required 0", busy); end
    if (req_ready !== 4'b0) begin fails++; $display("FAIL mid_rst_req_ready: got %b required 0000", req_ready); end
`ifdef BYTE_LANE_ARBITER_STATS_EN
    tests++;
    if (beat_count !== 32'd0 || grant_count !== 16'd0) begin
      fails++;
      $display("FAIL mid_rst_stats: got %0d/%0d required 0/0", beat_count, grant_count);
    end
`endif
    rst = 1'b0;
    clear_beats();
    // arbitration restarts at index 0, so req 0 wins before the replayed burst
    push_beat(0, 8'hD0, 1'b1, 1'b1);
    for (int j = 0; j < 4; j++) push_beat(2, 8'(8'hC1 + j), (j == 3), 1'b1);
    drive();
    wait_drain("reset_mid");
`ifdef BYTE_LANE_ARBITER_STATS_EN
    tests++;
    if (beat_count !== 32'd5 || grant_count !== 16'd2) begin
      fails++;
      $display("FAIL stats_after_replay: got beats=%0d grants=%0d required 5/2", beat_count, grant_count);
    end
`endif
  endtask

  initial begin
    clear_beats();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_burst_limit();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/byte_lane_arbiter.md
Name: byte_lane_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one 8-bit byte lane (the `in`→`out` passthrough DUT used in arcilator linked-driver tests) between several requesters.
- Grants the lane per burst and registers the selected byte into a single-entry output stage.
- Tags each output byte with its source index, so a C++ driver can check ordering and fairness cycle by cycle.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, lane width in bits.
- MAX_BURST, 4, max beats per grant before forced release (1..255).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_data  input  NUM_REQ*DATA_W  packed beats; requester i at bits [i*DATA_W +: DATA_W].
- req_last  input  NUM_REQ  beat is final of requester's burst.
- req_ready  output  NUM_REQ  beat accepted this cycle when valid&ready.
- out_valid  output  1  output register holds a beat.
- out_data  output  DATA_W  registered beat.
- out_src  output  $clog2(NUM_REQ)  index of requester that produced out_data.
- out_last  output  1  registered copy of req_last.
- out_ready  input  1  downstream accepts beat when out_valid&out_ready.
- busy  output  1  high while state is GRANT.

Behaviour:
- Reset (sync, rst=1 at edge) sets state to IDLE, rr_ptr to NUM_REQ-1, beat_cnt to 0, out_valid to 0, out_data/out_src/out_last to 0, busy to 0.
- req_ready is combinational and is all-zero during rst.
- States:
  - IDLE: if any req_valid, select the first valid index scanning rr_ptr+1, rr_ptr+2, … (mod NUM_REQ). Register it as gnt, set rr_ptr<=gnt, beat_cnt<=0, go to GRANT. No beat moves in IDLE.
  - GRANT: req_ready[gnt] = !out_valid | out_ready. All other req_ready bits are 0.
- On req handshake:
  - out_data<=req_data[gnt], out_src<=gnt, out_last<=req_last[gnt], out_valid<=1.
  - beat_cnt increments.
- GRANT→IDLE on a handshake whose req_last=1, or on a handshake that makes beat_cnt reach MAX_BURST. That handshake's beat is still forwarded.
- Requester dropping req_valid mid-burst does not release the grant. The lane stays held until last or the burst limit.
- Output stage: out_valid clears on out handshake unless a new req handshake occurs the same cycle (reload, out_valid stays 1). The output stage is full-throughput: with out_ready=1 held, one beat per cycle.
- Latency: req handshake at cycle N → out_valid/out_data visible at N+1.
- Grant-switch bubble: one IDLE cycle between bursts. The first beat of a new grant can handshake the cycle after IDLE.
- Backpressure: out_ready=0 with out_valid=1 holds out_data/out_src/out_last stable and deasserts req_ready.
- Fairness: after gnt=k, requester k has lowest priority at the next arbitration.
- NUM_REQ not a power of two: pointer wrap is explicit mod NUM_REQ, never an out-of-range index.
- Reset mid-burst: grant is dropped, the output beat is discarded (out_valid=0), and the next arbitration starts at index 0.

Optional Feature:
- Macro BYTE_LANE_ARBITER_STATS_EN.
- Defined:
  - Adds output port beat_count, 32 bits.
  - Increments by 1 on every out handshake (out_valid&out_ready) and wraps from 0xFFFFFFFF to 0.
  - Reset to 0.
  - Adds output port grant_count, 16 bits, incrementing on every IDLE→GRANT transition, wrapping, reset 0.
- Undefined: neither port exists and there are no counter flops. Functional behaviour is otherwise identical.

Test Plan:
- Reset check: hold rst=1 for 3 cycles with all req_valid=1 → out_valid=0, req_ready=0, busy=0 throughout; after release, first grant goes to requester 0.
- Single burst: req 2 sends 0x11,0x22,0x33 (last on 0x33), out_ready=1 → out_data 0x11,0x22,0x33 on consecutive cycles, out_src=2, out_last only with 0x33, then busy=0.
- Round robin: req 0 and req 1 continuously valid with 1-beat bursts (last=1) → out_src sequence 0,1,0,1 with one bubble between beats.
- Burst limit: req 3 streams 6 beats 0xA0..0xA5, last on 0xA5, req 1 also valid → 0xA0..0xA3 from src 3, then req 1's burst, then 0xA4,0xA5 from src 3.
- Backpressure: mid-burst drive out_ready=0 for 4 cycles with out_data=0x5A → out_data stays 0x5A, req_ready[gnt]=0; no beat lost or duplicated after out_ready=1.
- Reset mid-burst plus stats: assert rst after 2 of 4 beats → out_valid=0 next cycle, beat_count/grant_count=0 (with BYTE_LANE_ARBITER_STATS_EN); replayed burst completes normally.
